fp_sqrt_iter_core: RTL and testbench

//   Sequential IEEE-754 single-precision square-root core for the FP_SquareRoot datapath.

---
 rtl/fp_sqrt_iter_core.sv | 206 ++++++++++++++++++++
 tb/tb_fp_sqrt_iter_core.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_iter_core.sv
// Purpose : binary32 square root, restoring digit-by-digit, one root bit per clock.
// Latency : done_o 28 cycles after start acceptance (normal), 2 cycles (special operand).
// Backpres: start_i is only accepted in IDLE; requests in any other state are dropped.
module fp_sqrt_iter_core #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_BIAS   = 127,
  parameter int ROOT_BITS  = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  invalid_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_ROUND,
    S_FINISH
  } state_t;

  localparam logic [4:0]  LAST_ITER = 5'(ROOT_BITS - 1);
  localparam logic [9:0]  BIAS10    = 10'(EXP_BIAS);
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;

  state_t       state_q, state_d;
  logic [31:0]  op_q, op_d;
  logic [49:0]  rad_q, rad_d;
  logic [26:0]  rem_q, rem_d;
  logic [24:0]  root_q, root_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [7:0]   exp_q, exp_d;
  logic [31:0]  stage_res_q, stage_res_d;
  logic         stage_inv_q, stage_inv_d;
  logic [31:0]  result_q, result_d;
  logic         invalid_q, invalid_d;
  logic         done_q, done_d;

  // operand field decode and special-case classification
  logic         op_sign;
  logic [7:0]   op_exp;
  logic [22:0]  op_frac;
  logic         is_special;
  logic [31:0]  special_res;
  logic         special_inv;
  logic signed [9:0] e_unb;
  logic signed [9:0] e_adj;
  logic signed [9:0] e_res;
  logic         e_odd;
  logic [23:0]  mant;

  // classify the captured operand and prepare the normal-path radicand and exponent
  always_comb begin
    op_sign     = op_q[31];
    op_exp      = op_q[30:23];
    op_frac     = op_q[22:0];
    is_special  = 1'b1;
    special_res = 32'h0;
    special_inv = 1'b0;
    if (op_exp == 8'h00) begin
      // zero and denormals (flushed) keep their sign
      special_res = {op_sign, 31'h0};
    end else if (op_exp == 8'hFF && op_frac != 23'h0) begin
      special_res = QNAN;
      special_inv = 1'b1;
    end else if (op_sign) begin
      special_res = QNAN;
      special_inv = 1'b1;
    end else if (op_exp == 8'hFF) begin
      special_res = POS_INF;
    end else begin
      is_special  = 1'b0;
    end
    mant  = {1'b1, op_frac};
    e_unb = $signed({2'b00, op_exp}) - $signed(BIAS10);
    e_odd = e_unb[0];
    e_adj = e_odd ? (e_unb - 10'sd1) : e_unb;
    e_res = (e_adj >>> 1) + $signed(BIAS10);
  end

  // one restoring-sqrt step and the final rounding, both working from registered state
  logic [26:0]  rem_shift;
  logic [27:0]  trial;
  logic         keep;
  logic [24:0]  sig_rnd;
  logic         rnd_carry;
  logic [22:0]  frac_rnd;
  logic [7:0]   exp_rnd;

  // datapath arithmetic for ITER and ROUND
  always_comb begin
    rem_shift = 27'({rem_q, rad_q[49:48]});
    trial     = {1'b0, rem_shift} - {1'b0, root_q, 2'b01};
    keep      = ~trial[27];
    sig_rnd   = {1'b0, root_q[24:1]} + {24'h0, root_q[0]};
    rnd_carry = sig_rnd[24];
    // a carry out means the significand became exactly 2.0: renormalise to 1.0
    frac_rnd  = rnd_carry ? 23'h0 : 23'(sig_rnd);
    exp_rnd   = exp_q + {7'h0, rnd_carry};
  end

  // next-state and register-update logic of the control FSM
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    stage_res_d = stage_res_q;
    stage_inv_d = stage_inv_q;
    result_d    = result_q;
    invalid_d   = invalid_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = operand_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (is_special) begin
          stage_res_d = special_res;
          stage_inv_d = special_inv;
          state_d     = S_FINISH;
        end else begin
          // odd exponent: fold one factor of two into the radicand
          rad_d       = e_odd ? {mant, 26'h0} : {1'b0, mant, 25'h0};
          rem_d       = 27'h0;
          root_d      = 25'h0;
          cnt_d       = 5'h0;
          exp_d       = e_res[7:0];
          stage_inv_d = 1'b0;
          state_d     = S_ITER;
        end
      end
      S_ITER: begin
        rad_d  = {rad_q[47:0], 2'b00};
        rem_d  = keep ? 27'(trial) : rem_shift;
        root_d = {root_q[23:0], keep};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        stage_res_d = {1'b0, exp_rnd, frac_rnd};
        state_d     = S_FINISH;
      end
      S_FINISH: begin
        result_d  = stage_res_q;
        invalid_d = stage_inv_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 32'h0;
      rad_q       <= 50'h0;
      rem_q       <= 27'h0;
      root_q      <= 25'h0;
      cnt_q       <= 5'h0;
      exp_q       <= 8'h0;
      stage_res_q <= 32'h0;
      stage_inv_q <= 1'b0;
      result_q    <= 32'h0;
      invalid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      stage_res_q <= stage_res_d;
      stage_inv_q <= stage_inv_d;
      result_q    <= result_d;
      invalid_q   <= invalid_d;
      done_q      <= done_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign invalid_o = invalid_q;

endmodule

// File: tb/tb_fp_sqrt_iter_core.sv
// Directed bench for fp_sqrt_iter_core: hand-computed roots, specials,
// ignored restarts and mid-operation reset.
module tb_fp_sqrt_iter_core;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [31:0] operand_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        invalid_o;

  int checks;
  int errors;

  fp_sqrt_iter_core #(
    .DATA_WIDTH(32),
    .EXP_BIAS  (127),
    .ROOT_BITS (25)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .operand_i(operand_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .invalid_o(invalid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Issue one operation and check latency, result, flag, and that nothing
  // else completes afterwards. With ign set, start_i is held high (with a
  // different operand) for the edges 5..20 after acceptance.
  task automatic run_op(input string tag, input logic [31:0] op,
                        input logic [31:0] want_res, input logic want_inv,
                        input int want_lat, input bit ign);
    int lat;
    int extra;
    lat = 0;
    @(negedge clk);
    start_i   = 1'b1;
    operand_i = op;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    operand_i = 32'hDEAD_BEEF;
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        lat = n;
        start_i = 1'b0;
      end else if (ign && n >= 4 && n <= 19) begin
        start_i   = 1'b1;
        operand_i = 32'h3E80_0000;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
    chk({tag, "_res"}, result_o, want_res);
    chk({tag, "_inv"}, 32'(invalid_o), 32'(want_inv));
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    extra = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done_o) extra++;
    end
    chk({tag, "_extra_done"}, 32'(extra), 32'd0);
    chk({tag, "_held"}, result_o, want_res);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    operand_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_res", result_o, 32'h0);
    chk("rst_inv", 32'(invalid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // normal operands
    run_op("sqrt4",    32'h4080_0000, 32'h4000_0000, 1'b0, 28, 1'b0);
    run_op("sqrt2",    32'h4000_0000, 32'h3FB5_04F3, 1'b0, 28, 1'b0);
    run_op("sqrt025",  32'h3E80_0000, 32'h3F00_0000, 1'b0, 28, 1'b0);
    run_op("sqrt_max", 32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0, 28, 1'b0);

    // special operands
    run_op("neg_zero", 32'h8000_0000, 32'h8000_0000, 1'b0, 2, 1'b0);
    run_op("pos_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b0, 2, 1'b0);
    run_op("neg_one",  32'hBF80_0000, 32'h7FC0_0000, 1'b1, 2, 1'b0);
    run_op("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 2, 1'b0);
    run_op("nan",      32'h7FA0_0000, 32'h7FC0_0000, 1'b1, 2, 1'b0);

    // restart requests during an operation are dropped
    run_op("ignore",   32'h4080_0000, 32'h4000_0000, 1'b0, 28, 1'b1);

    // reset in the middle of the iteration aborts everything
    @(negedge clk);
    start_i   = 1'b1;
    operand_i = 32'h4000_0000;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_res", result_o, 32'h0);
    chk("midrst_inv", 32'(invalid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 32'h4080_0000, 32'h4000_0000, 1'b0, 28, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
